seg7_scan_driver: RTL

//  Time-multiplexed driver for a w_digit-wide 7-segment display with decimal points.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_scan_driver_strobe_gen.sv | 29 ++
 rtl/seg7_scan_driver.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared helpers for the 7-segment scan driver: glyph table, dot lane index and
// a clog2 that never collapses to a zero-width vector.
package seg7_pkg;

  localparam int SEG_DOT = 0;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  // Segments a..g on bits 6..0
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_strobe_gen.sv
// Free-running divider: one-cycle tick on the last count of every period.
module strobe_gen
  import seg7_pkg::*;
#(
  parameter int period = 1
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int CW = clog2_min1(period);
  localparam logic [CW-1:0] LAST = CW'(period - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with snapshot, PWM dimming, blank/blink,
// leading-zero suppression, configurable pin polarity and a frame strobe.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int w_digit        = 8,
  parameter int w_bright       = 4,
  parameter int clk_mhz        = 50,
  parameter int update_hz      = 4,
  parameter int scan_hz        = 1000,
  parameter int blink_hz       = 2,
  parameter bit seg_active_low = 1'b0,
  parameter bit dig_active_low = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [w_digit*4-1:0]   number,
  input  logic [w_digit-1:0]     dots,
  input  logic [w_digit-1:0]     blank,
  input  logic [w_digit-1:0]     blink,
  input  logic                   lz_blank,
  input  logic [w_bright-1:0]    brightness,
  output logic [7:0]             abcdefgh,
  output logic [w_digit-1:0]     digit,
  output logic                   frame_tick
);

  localparam int CLK_HZ  = clk_mhz * 1000000;
  localparam int RAW_UPD = CLK_HZ / update_hz;
  localparam int RAW_SUB = CLK_HZ / (scan_hz * (2 ** w_bright));
  localparam int RAW_BLK = CLK_HZ / (2 * blink_hz);
  localparam int T_UPD   = (RAW_UPD < 1) ? 1 : RAW_UPD;
  localparam int T_SUB   = (RAW_SUB < 1) ? 1 : RAW_SUB;
  localparam int T_BLK   = (RAW_BLK < 1) ? 1 : RAW_BLK;
  localparam int IW      = clog2_min1(w_digit);

  localparam logic [IW-1:0]      LAST_IDX = IW'(w_digit - 1);
  localparam logic [7:0]         SEG_OFF  = {8{seg_active_low}};
  localparam logic [w_digit-1:0] DIG_OFF  = {w_digit{dig_active_low}};

  logic w_upd_tick, w_sub_tick, w_blk_tick, w_pwm_wrap;

  strobe_gen #(.period(T_UPD)) u_upd (.clk(clk), .rst(rst), .o_tick(w_upd_tick));
  strobe_gen #(.period(T_SUB)) u_sub (.clk(clk), .rst(rst), .o_tick(w_sub_tick));
  strobe_gen #(.period(T_BLK)) u_blk (.clk(clk), .rst(rst), .o_tick(w_blk_tick));

  logic [w_digit*4-1:0] r_number;
  logic [w_digit-1:0]   r_dots, r_blank, r_blink, r_lz;
  logic [w_bright-1:0]  r_pwm, r_bright;
  logic [IW-1:0]        r_index;
  logic                 r_blink_phase, r_slot_start, r_frame_tick;
  logic [7:0]           r_abcdefgh;
  logic [w_digit-1:0]   r_digit;

  // Leading-zero mask of the incoming number; digit 0 is never suppressed.
  logic [w_digit-1:0] w_lz_next;
  logic               w_zero_above;
  always_comb begin
    w_lz_next    = '0;
    w_zero_above = lz_blank;
    for (int i = w_digit - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above && (number[4*i +: 4] == 4'h0);
      w_lz_next[i] = w_zero_above;
    end
  end

  assign w_pwm_wrap = w_sub_tick && (r_pwm == {w_bright{1'b1}});

  logic [3:0]         w_nib;
  logic               w_dot, w_blank, w_blink, w_lz, w_lit;
  logic [w_digit-1:0] w_onehot;
  logic [6:0]         w_glyph;
  logic [7:0]         w_seg_raw, w_seg_next;
  logic [w_digit-1:0] w_dig_next;

  always_comb begin
    w_nib    = 4'h0;
    w_dot    = 1'b0;
    w_blank  = 1'b0;
    w_blink  = 1'b0;
    w_lz     = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < w_digit; i++) begin
      if (r_index == IW'(i)) begin
        w_nib       = r_number[4*i +: 4];
        w_dot       = r_dots[i];
        w_blank     = r_blank[i];
        w_blink     = r_blink[i];
        w_lz        = r_lz[i];
        w_onehot[i] = 1'b1;
      end
    end
    // A suppressed zero with no dot has nothing to show, so keep its anode off too.
    w_lit = (r_pwm < r_bright) && !w_blank && !(w_blink && r_blink_phase)
            && !(w_lz && !w_dot);
    w_glyph            = w_lz ? 7'h00 : hex7seg(w_nib);
    w_seg_raw          = {w_glyph, 1'b0};
    w_seg_raw[SEG_DOT] = w_seg_raw[SEG_DOT] | w_dot;
    w_seg_next         = w_lit ? (w_seg_raw ^ SEG_OFF) : SEG_OFF;
    w_dig_next         = w_lit ? (w_onehot ^ DIG_OFF) : DIG_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_number <= '0;
      r_dots   <= '0;
      r_blank  <= '0;
      r_blink  <= '0;
      r_lz     <= '0;
    end else if (w_upd_tick) begin
      r_number <= number;
      r_dots   <= dots;
      r_blank  <= blank;
      r_blink  <= blink;
      r_lz     <= w_lz_next;
    end
  end

  // Brightness is picked up during reset so the very first slot is already visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm         <= '0;
      r_bright      <= brightness;
      r_index       <= '0;
      r_blink_phase <= 1'b0;
      r_slot_start  <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_abcdefgh    <= SEG_OFF;
      r_digit       <= DIG_OFF;
    end else begin
      if (w_sub_tick) r_pwm <= r_pwm + 1'b1;
      if (w_pwm_wrap) begin
        r_bright <= brightness;
        r_index  <= (r_index == LAST_IDX) ? '0 : r_index + 1'b1;
      end
      if (w_blk_tick) r_blink_phase <= ~r_blink_phase;
      r_slot_start <= w_pwm_wrap;
      r_frame_tick <= r_slot_start && (r_index == '0);
      r_abcdefgh   <= w_seg_next;
      r_digit      <= w_dig_next;
    end
  end

  assign abcdefgh   = r_abcdefgh;
  assign digit      = r_digit;
  assign frame_tick = r_frame_tick;

endmodule
